// File: rtl/session_manager.sv
// session_manager: game-session controller (login gate, high-score table, inactivity timeout, logout pulse)
module session_manager #(
    parameter int          NUM_PLAYERS    = 5,
    parameter int          SCORE_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000_000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Successful,
    input  logic [4:0]         PlayerID,
    input  logic               LogOutBtn,
    input  logic               StartGame,
    input  logic               Activity,
    input  logic               GameOver,
    input  logic [SCORE_W-1:0] Score,
    output logic               LogOutPulse,
    output logic               GameEnable,
    output logic [4:0]         ActivePlayer,
    output logic [SCORE_W-1:0] HighScore,
    output logic               NewHighScore,
    output logic [2:0]         SessionState
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] PLAYING = 3'd2;
    localparam logic [2:0] ENDED   = 3'd3;
    localparam logic [2:0] LOGOUT  = 3'd4;
    localparam logic [2:0] DRAIN   = 3'd5;
    localparam logic [4:0]  ID_LIMIT = 5'(NUM_PLAYERS);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    logic [SCORE_W-1:0] hsTable [NUM_PLAYERS];
    logic [2:0]         stateNext;
    logic [4:0]         activeNext;
    logic [SCORE_W-1:0] curScore;
    logic [SCORE_W-1:0] nextScore;
    logic [31:0]        timer;
    logic               timeoutHit;
    logic               playOrEnd;
    logic               clearTimer;
    logic               writeHs;

    assign playOrEnd  = SessionState == PLAYING || SessionState == ENDED;
    assign clearTimer = Activity || StartGame || GameOver;

    // table lookups for the current and the upcoming session owner
    always_comb begin
        curScore  = '0;
        nextScore = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (ActivePlayer == 5'(i)) curScore = hsTable[i];
            if (activeNext == 5'(i)) nextScore = hsTable[i];
        end
    end

    // a finished game is recorded even if logout/timeout wins the transition, but not on a dropped login
    assign writeHs = SessionState == PLAYING && Successful && GameOver && Score > curScore;

    // next state: dropped login first, then logout/timeout, then game events
    always_comb begin
        stateNext = SessionState;
        case (SessionState)
            IDLE:    stateNext = !Successful ? IDLE : (PlayerID < ID_LIMIT) ? START : LOGOUT;
            START:   stateNext = Successful ? PLAYING : IDLE;
            PLAYING: stateNext = !Successful ? IDLE : (LogOutBtn || timeoutHit) ? LOGOUT : GameOver ? ENDED : PLAYING;
            ENDED:   stateNext = !Successful ? IDLE : (LogOutBtn || timeoutHit) ? LOGOUT : StartGame ? PLAYING : ENDED;
            LOGOUT:  stateNext = DRAIN;
            DRAIN:   stateNext = Successful ? DRAIN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // session owner is latched on a valid login and released whenever the session returns to IDLE
    assign activeNext = stateNext == IDLE ? 5'd0 : (SessionState == IDLE && stateNext == START) ? PlayerID : ActivePlayer;

    // FSM, registered outputs and inactivity timer
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            SessionState <= IDLE;
            ActivePlayer <= '0;
            GameEnable   <= 1'b0;
            LogOutPulse  <= 1'b0;
            NewHighScore <= 1'b0;
            HighScore    <= '0;
            timer        <= '0;
            timeoutHit   <= 1'b0;
        end else begin
            SessionState <= stateNext;
            ActivePlayer <= activeNext;
            GameEnable   <= stateNext == PLAYING;
            LogOutPulse  <= stateNext == LOGOUT;
            NewHighScore <= writeHs;
            HighScore    <= stateNext == IDLE ? '0 : writeHs ? Score : nextScore;
            timer        <= !playOrEnd || clearTimer ? '0 : (timer == '1 ? timer : timer + 32'd1);
            timeoutHit   <= playOrEnd && !clearTimer && timer == TO_LAST;
        end
    end

    // high-score table, cleared only by reset so it survives across sessions
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_PLAYERS; i++) hsTable[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++)
                if (writeHs && ActivePlayer == 5'(i)) hsTable[i] <= Score;
        end
    end
endmodule

// File: tb/tb_session_manager.sv
// tb_session_manager: directed self-checking bench for session_manager
module tb_session_manager;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Successful = 1'b0;
    logic [4:0]  PlayerID = '0;
    logic        LogOutBtn = 1'b0;
    logic        StartGame = 1'b0;
    logic        Activity = 1'b0;
    logic        GameOver = 1'b0;
    logic [15:0] Score = '0;
    logic        LogOutPulse;
    logic        GameEnable;
    logic [4:0]  ActivePlayer;
    logic [15:0] HighScore;
    logic        NewHighScore;
    logic [2:0]  SessionState;
    int checks = 0;
    int errors = 0;

    session_manager #(.NUM_PLAYERS(5), .SCORE_W(16), .TIMEOUT_CYCLES(100)) dut (
        .Clk(Clk), .Reset(Reset), .Successful(Successful), .PlayerID(PlayerID),
        .LogOutBtn(LogOutBtn), .StartGame(StartGame), .Activity(Activity),
        .GameOver(GameOver), .Score(Score), .LogOutPulse(LogOutPulse),
        .GameEnable(GameEnable), .ActivePlayer(ActivePlayer), .HighScore(HighScore),
        .NewHighScore(NewHighScore), .SessionState(SessionState)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic login(input logic [4:0] id);
        Successful = 1'b1;
        PlayerID = id;
        step();
        step();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_state"}, 32'(SessionState), 0);
        check({tag, "_en"}, 32'(GameEnable), 0);
        check({tag, "_lo"}, 32'(LogOutPulse), 0);
        check({tag, "_ap"}, 32'(ActivePlayer), 0);
        check({tag, "_hs"}, 32'(HighScore), 0);
        check({tag, "_nhs"}, 32'(NewHighScore), 0);
    endtask

    initial begin
        int n;
        step();
        checkAllZero("reset");
        Reset = 1'b1;
        step();
        // login as player 2
        Successful = 1'b1;
        PlayerID = 5'd2;
        step();
        check("login_start", 32'(SessionState), 1);
        check("login_ap", 32'(ActivePlayer), 2);
        check("login_en0", 32'(GameEnable), 0);
        step();
        check("login_play", 32'(SessionState), 2);
        check("login_en1", 32'(GameEnable), 1);
        check("login_hs", 32'(HighScore), 0);
        // first score
        GameOver = 1'b1; Score = 16'h0123;
        step();
        GameOver = 1'b0;
        check("go1_state", 32'(SessionState), 3);
        check("go1_nhs", 32'(NewHighScore), 1);
        check("go1_hs", 32'(HighScore), 16'h0123);
        check("go1_en", 32'(GameEnable), 0);
        step();
        check("go1_nhs_off", 32'(NewHighScore), 0);
        // equal score: no write, no pulse
        StartGame = 1'b1; step(); StartGame = 1'b0;
        check("sg_state", 32'(SessionState), 2);
        GameOver = 1'b1; Score = 16'h0123;
        step();
        GameOver = 1'b0;
        check("eq_state", 32'(SessionState), 3);
        check("eq_nhs", 32'(NewHighScore), 0);
        check("eq_hs", 32'(HighScore), 16'h0123);
        // higher score
        StartGame = 1'b1; step(); StartGame = 1'b0;
        GameOver = 1'b1; Score = 16'h0200;
        step();
        GameOver = 1'b0;
        check("hi_nhs", 32'(NewHighScore), 1);
        check("hi_hs", 32'(HighScore), 16'h0200);
        // timeout without activity, counted from PLAYING entry
        StartGame = 1'b1; step(); StartGame = 1'b0;
        check("to_play", 32'(SessionState), 2);
        n = 0;
        do begin step(); n++; end while (!LogOutPulse && n < 300);
        check("to_latency", 32'(n), 101);
        check("to_state", 32'(SessionState), 4);
        step();
        check("to_pulse_off", 32'(LogOutPulse), 0);
        check("to_drain", 32'(SessionState), 5);
        Successful = 1'b0;
        step();
        check("to_idle", 32'(SessionState), 0);
        check("to_idle_ap", 32'(ActivePlayer), 0);
        check("to_idle_hs", 32'(HighScore), 0);
        // timeout with one activity pulse at cycle 50
        login(5'd2);
        check("act_hs_persist", 32'(HighScore), 16'h0200);
        n = 0;
        do begin
            n++;
            Activity = (n == 50);
            step();
            Activity = 1'b0;
        end while (!LogOutPulse && n < 400);
        check("act_latency", 32'(n), 151);
        step();
        Successful = 1'b0;
        step();
        check("act_idle", 32'(SessionState), 0);
        // unknown ID is forced out and held in DRAIN
        Successful = 1'b1; PlayerID = 5'd7;
        step();
        check("bad_state", 32'(SessionState), 4);
        check("bad_pulse", 32'(LogOutPulse), 1);
        check("bad_en", 32'(GameEnable), 0);
        step();
        check("bad_drain", 32'(SessionState), 5);
        check("bad_pulse_off", 32'(LogOutPulse), 0);
        step();
        check("bad_drain_hold", 32'(SessionState), 5);
        Successful = 1'b0;
        step();
        check("bad_idle", 32'(SessionState), 0);
        login(5'd2);
        check("persist_hs", 32'(HighScore), 16'h0200);
        check("persist_ap", 32'(ActivePlayer), 2);
        // GameOver and logout together
        GameOver = 1'b1; LogOutBtn = 1'b1; Score = 16'h0300;
        step();
        GameOver = 1'b0; LogOutBtn = 1'b0;
        check("sim_state", 32'(SessionState), 4);
        check("sim_pulse", 32'(LogOutPulse), 1);
        check("sim_nhs", 32'(NewHighScore), 1);
        check("sim_hs", 32'(HighScore), 16'h0300);
        check("sim_en", 32'(GameEnable), 0);
        step();
        check("sim_pulse_off", 32'(LogOutPulse), 0);
        Successful = 1'b0;
        step();
        // external drop of the login while PLAYING
        login(5'd2);
        check("drop_hs", 32'(HighScore), 16'h0300);
        Successful = 1'b0;
        step();
        check("drop_state", 32'(SessionState), 0);
        check("drop_pulse", 32'(LogOutPulse), 0);
        check("drop_en", 32'(GameEnable), 0);
        check("drop_hs0", 32'(HighScore), 0);
        step();
        check("drop_pulse2", 32'(LogOutPulse), 0);
        // asynchronous reset mid-session clears outputs and table
        login(5'd2);
        check("rst_pre_en", 32'(GameEnable), 1);
        #3 Reset = 1'b0;
        #1;
        checkAllZero("arst");
        step();
        Reset = 1'b1;
        login(5'd2);
        check("rst_play", 32'(SessionState), 2);
        check("rst_hs", 32'(HighScore), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/session_manager.md
# session_manager

Game-session controller sitting directly downstream of the multi-user authentication block. It consumes `Successful` and `PlayerID` and owns the session from login to logout:
- gates the game engine via `GameEnable`;
- keeps a per-player high-score table;
- enforces an inactivity timeout;
- generates the one-cycle `LogOutPulse` that the authentication block consumes to drop the login.

## Interface
Parameters:
- `NUM_PLAYERS`, 5, number of valid player indices (0..NUM_PLAYERS-1); high-score table depth.
- `SCORE_W`, 16, score width.
- `TIMEOUT_CYCLES`, 1_500_000_000, inactivity limit in clock cycles (30 s at 50 MHz); counter is 32 bits.

Ports:
- `Clk`  in  1  system clock; all logic rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Successful`  in  1  authentication-done level from the authentication block.
- `PlayerID`  in  5  authenticated player index; valid while `Successful`=1.
- `LogOutBtn`  in  1  one-cycle logout request (already debounced/pulsed).
- `StartGame`  in  1  one-cycle new-game request.
- `Activity`  in  1  one-cycle pulse on any player input.
- `GameOver`  in  1  one-cycle end-of-game pulse; `Score` is valid in the same cycle.
- `Score`  in  SCORE_W  final score of the ended game.
- `LogOutPulse`  out  1  one-cycle logout command to the authentication block.
- `GameEnable`  out  1  high while in PLAYING.
- `ActivePlayer`  out  5  latched player index of the current session.
- `HighScore`  out  SCORE_W  table entry for `ActivePlayer`.
- `NewHighScore`  out  1  one-cycle pulse when the table entry is updated.
- `SessionState`  out  3  state encoding: IDLE=0, START=1, PLAYING=2, ENDED=3, LOGOUT=4, DRAIN=5.

## Operation
Reset values:
- All outputs 0.
- State IDLE.
- Timer 0.
- All table entries 0. The table is cleared only by `Reset`; it persists across sessions.

State transitions, by state:
- **IDLE:**
  - `Successful`=1 and `PlayerID`<NUM_PLAYERS: latch `ActivePlayer`<=`PlayerID`, go to START.
  - `Successful`=1 and `PlayerID`>=NUM_PLAYERS: go to LOGOUT (force logout of an unknown ID).
- **START:** clear timer; go to PLAYING.
- **PLAYING:**
  - `GameOver`: update the table (see below); go to ENDED.
  - `LogOutBtn` or timeout: go to LOGOUT.
- **ENDED:**
  - `StartGame`: go to PLAYING.
  - `LogOutBtn` or timeout: go to LOGOUT.
- **LOGOUT:** `LogOutPulse`=1 for exactly this one cycle; unconditionally go to DRAIN.
- **DRAIN:** wait until `Successful`=0, then go to IDLE. `ActivePlayer` clears to 0 on that transition.

Transition rules that apply across states:
- `Successful` falling while in START, PLAYING or ENDED: go to IDLE immediately, with no `LogOutPulse`. This overrides every other condition.
- Priority in PLAYING and ENDED: `Successful`=0, then `LogOutBtn`/timeout, then `GameOver`/`StartGame`.
- `GameOver` together with `LogOutBtn` in PLAYING: the score is still recorded, and the next state is LOGOUT.

Table update:
- On `GameOver` in PLAYING, if `Score` > `table[ActivePlayer]` (strictly greater, unsigned), write it and pulse `NewHighScore` on the next cycle.
- An equal score does not write and does not pulse.

Timer:
- Increments every cycle in PLAYING and ENDED.
- Clears on `Activity`, `StartGame`, `GameOver`, and on entry to START.
- Timeout fires when the timer equals TIMEOUT_CYCLES-1 with no clearing pulse in that same cycle.
- The timer saturates and never wraps.
- `Activity` outside PLAYING and ENDED is ignored.

## Timing
- All outputs are registered, so each output reflects the state after an edge.
- Login latency: `Successful` sampled high at edge k gives START after edge k with `ActivePlayer` valid. Edge k+1 gives PLAYING, with `GameEnable`=1 and `HighScore` valid.
- `HighScore` updates one cycle after a table write, coincident with the `NewHighScore` pulse.
- `HighScore` is 0 in IDLE.
- Logout: `LogOutBtn` at edge m gives `LogOutPulse`=1 during cycle m+1 only. `GameEnable` falls at edge m.
- Timeout: a session with no activity asserts `LogOutPulse` exactly TIMEOUT_CYCLES+1 cycles after entering PLAYING.
- `Reset` asserted mid-session: all outputs return to their reset values asynchronously, and the table is cleared.

## Test plan
All scenarios use `NUM_PLAYERS`=5 and `TIMEOUT_CYCLES`=100.
- **Login:** `PlayerID`=2, `Successful` 0→1 → START one cycle, then PLAYING; `GameEnable`=1 two cycles after the rise; `ActivePlayer`=2; `HighScore`=0.
- **High score:**
  - `GameOver` with `Score`=0x0123 → ENDED, `NewHighScore` pulse, `HighScore`=0x0123.
  - After `StartGame`, `GameOver` with 0x0123 → no pulse.
  - Then `GameOver` with 0x0200 → pulse, `HighScore`=0x0200.
- **Timeout:** no `Activity` → `LogOutPulse` single cycle at 101 cycles after PLAYING entry. With one `Activity` at cycle 50, the pulse occurs at cycle 151.
- **Invalid ID and persistence:**
  - `PlayerID`=7 with `Successful`=1 → LOGOUT pulse, then DRAIN until `Successful`=0, then IDLE.
  - Re-login as player 2 → `HighScore`=0x0200 (persisted).
- **Simultaneous events:** `GameOver`(Score=0x0300) and `LogOutBtn` in the same cycle → table written, `NewHighScore` pulse, `LogOutPulse` next cycle.
- **External drop and reset:**
  - `Successful` falls in PLAYING → IDLE, no `LogOutPulse`.
  - `Reset` low mid-PLAYING → all outputs 0, and `HighScore` after the next login is 0.
